// File: rtl/regfile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// regfile_writeback_pkg
// Shared definitions for the integer register file / write-back stage:
//   XLEN        - register data width
//   REG_ADDR_W  - register address width (x0..x31)
//   NUM_REGS    - number of architectural registers
//   REG_ZERO    - address of the hardwired-zero register
//   wb_entry    - one pending write (destination address + data)
// -----------------------------------------------------------------------------
package regfile_writeback_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_entry;

endpackage

// File: rtl/regfile_writeback_pending_queue.sv
// -----------------------------------------------------------------------------
// wb_pending_queue
// Circular FIFO of pending ALU writes with two parallel address lookups that
// return the newest matching entry (used for read bypass).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   push, push_entry          enqueue one entry (ignored when full)
//   pop                       dequeue the head (ignored when empty)
//   head                      oldest entry
//   count, full, empty        occupancy
//   lookup1_addr/_hit/_data   lookup port 1: newest entry with matching addr
//   lookup2_addr/_hit/_data   lookup port 2: newest entry with matching addr
// -----------------------------------------------------------------------------
module wb_pending_queue
   import regfile_writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  wb_entry                      push_entry,
   input  logic                         pop,
   output wb_entry                      head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   input  logic [REG_ADDR_W-1:0]        lookup1_addr,
   output logic                         lookup1_hit,
   output logic [XLEN-1:0]              lookup1_data,
   input  logic [REG_ADDR_W-1:0]        lookup2_addr,
   output logic                         lookup2_hit,
   output logic [XLEN-1:0]              lookup2_data
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_IDX = (PTR_W+1)'(DEPTH);

   wb_entry            mem_r [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               push_ok_s;
   logic               pop_ok_s;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if ({1'b0, p} == (DEPTH_IDX - {{PTR_W{1'b0}}, 1'b1})) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + {{(PTR_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Physical slot of the entry 'off' positions after the head.
   function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   off);
      logic [PTR_W:0] s;
      s = {1'b0, base} + off;
      if (s >= DEPTH_IDX) begin
         s = s - DEPTH_IDX;
      end else begin
         s = s;
      end
      return s[PTR_W-1:0];
   endfunction

   assign full      = (count_r == DEPTH_CNT);
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{addr: 5'd0, data: 32'd0};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Scan oldest to newest so the last match (the newest entry) wins.
   always_comb begin
      lookup1_hit  = 1'b0;
      lookup1_data = {XLEN{1'b0}};
      lookup2_hit  = 1'b0;
      lookup2_data = {XLEN{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_r) &&
             (mem_r[slot_of(rd_ptr_r, (PTR_W+1)'(i))].addr == lookup1_addr)) begin
            lookup1_hit  = 1'b1;
            lookup1_data = mem_r[slot_of(rd_ptr_r, (PTR_W+1)'(i))].data;
         end else begin
            lookup1_hit  = lookup1_hit;
            lookup1_data = lookup1_data;
         end
         if ((CNT_W'(i) < count_r) &&
             (mem_r[slot_of(rd_ptr_r, (PTR_W+1)'(i))].addr == lookup2_addr)) begin
            lookup2_hit  = 1'b1;
            lookup2_data = mem_r[slot_of(rd_ptr_r, (PTR_W+1)'(i))].data;
         end else begin
            lookup2_hit  = lookup2_hit;
            lookup2_data = lookup2_data;
         end
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// x0..x31 integer register file with a merged write-back stage. Loads from the
// memory controller always win the single write port; ALU writes that collide
// with a load (or arrive behind queued ones) wait in a small pending queue.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   load_write_req/_addr/_data           load result stream (oldest source)
//   alu_write_req/_addr/_data            ALU/jump result stream (youngest)
//   src1_addr/src1_value                 combinational read port 1 (bypassed)
//   src2_addr/src2_value                 combinational read port 2 (bypassed)
//   wb_stall                             queue full, upstream holds ALU write
//   queue_count                          pending-queue occupancy
// -----------------------------------------------------------------------------
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int QUEUE_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               load_write_req,
   input  logic [REG_ADDR_W-1:0]              load_write_addr,
   input  logic [XLEN-1:0]                    load_write_data,
   input  logic                               alu_write_req,
   input  logic [REG_ADDR_W-1:0]              alu_write_addr,
   input  logic [XLEN-1:0]                    alu_write_data,
   input  logic [REG_ADDR_W-1:0]              src1_addr,
   input  logic [REG_ADDR_W-1:0]              src2_addr,
   output logic [XLEN-1:0]                    src1_value,
   output logic [XLEN-1:0]                    src2_value,
   output logic                               wb_stall,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

   logic [XLEN-1:0]       regs_r [NUM_REGS];

   wb_entry               q_head_s;
   logic                  q_full_s;
   logic                  q_empty_s;
   logic                  q_push_s;
   logic                  q_pop_s;
   logic                  q_hit1_s;
   logic                  q_hit2_s;
   logic [XLEN-1:0]       q_data1_s;
   logic [XLEN-1:0]       q_data2_s;

   logic                  alu_take_s;
   logic                  commit_en_s;
   logic [REG_ADDR_W-1:0] commit_addr_s;
   logic [XLEN-1:0]       commit_data_s;

   // Youngest-first bypass: accepted ALU input, queue (newest first), load, array.
   function automatic logic [XLEN-1:0] bypass(
      input logic [REG_ADDR_W-1:0] a,
      input logic                  alu_take,
      input logic [REG_ADDR_W-1:0] alu_addr,
      input logic [XLEN-1:0]       alu_data,
      input logic                  q_hit,
      input logic [XLEN-1:0]       q_data,
      input logic                  load_req,
      input logic [REG_ADDR_W-1:0] load_addr,
      input logic [XLEN-1:0]       load_data,
      input logic [XLEN-1:0]       arr_data);
      if (a == REG_ZERO) begin
         return {XLEN{1'b0}};
      end else if (alu_take && (alu_addr == a)) begin
         return alu_data;
      end else if (q_hit) begin
         return q_data;
      end else if (load_req && (load_addr == a)) begin
         return load_data;
      end else begin
         return arr_data;
      end
   endfunction

   // wb_stall depends only on the registered occupancy, so a stalled ALU
   // write is neither accepted nor forwarded. x0 writes are dropped here.
   assign alu_take_s = alu_write_req & ~q_full_s & (alu_write_addr != REG_ZERO);
   assign q_push_s   = alu_take_s & (load_write_req | ~q_empty_s);
   assign wb_stall   = q_full_s;

   wb_pending_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset_n      (reset_n),
      .push         (q_push_s),
      .push_entry   ('{addr: alu_write_addr, data: alu_write_data}),
      .pop          (q_pop_s),
      .head         (q_head_s),
      .count        (queue_count),
      .full         (q_full_s),
      .empty        (q_empty_s),
      .lookup1_addr (src1_addr),
      .lookup1_hit  (q_hit1_s),
      .lookup1_data (q_data1_s),
      .lookup2_addr (src2_addr),
      .lookup2_hit  (q_hit2_s),
      .lookup2_data (q_data2_s)
   );

   // Commit selection in age order: load, then queue head, then direct ALU.
   // A load to x0 still occupies the write port for that cycle.
   always_comb begin
      commit_en_s   = 1'b0;
      commit_addr_s = REG_ZERO;
      commit_data_s = {XLEN{1'b0}};
      q_pop_s       = 1'b0;
      if (load_write_req) begin
         commit_en_s   = (load_write_addr != REG_ZERO);
         commit_addr_s = load_write_addr;
         commit_data_s = load_write_data;
      end else if (!q_empty_s) begin
         commit_en_s   = 1'b1;
         commit_addr_s = q_head_s.addr;
         commit_data_s = q_head_s.data;
         q_pop_s       = 1'b1;
      end else if (alu_take_s) begin
         commit_en_s   = 1'b1;
         commit_addr_s = alu_write_addr;
         commit_data_s = alu_write_data;
      end else begin
         commit_en_s   = 1'b0;
      end
   end

   // Register array write port; x0 is never written and stays zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (commit_en_s && (commit_addr_s != REG_ZERO)) begin
            regs_r[commit_addr_s] <= commit_data_s;
         end
      end
   end

   assign src1_value = bypass(src1_addr, alu_take_s, alu_write_addr, alu_write_data,
                              q_hit1_s, q_data1_s, load_write_req, load_write_addr,
                              load_write_data, regs_r[src1_addr]);
   assign src2_value = bypass(src2_addr, alu_take_s, alu_write_addr, alu_write_data,
                              q_hit2_s, q_data2_s, load_write_req, load_write_addr,
                              load_write_data, regs_r[src2_addr]);

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
// Directed scenarios plus randomized traffic against a queue-based model of
// the write-back rules; outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

   localparam int DEPTH = 2;

   logic                         clk = 1'b0;
   logic                         reset_n = 1'b0;
   logic                         load_write_req = 1'b0;
   logic [4:0]                   load_write_addr = 5'd0;
   logic [31:0]                  load_write_data = 32'd0;
   logic                         alu_write_req = 1'b0;
   logic [4:0]                   alu_write_addr = 5'd0;
   logic [31:0]                  alu_write_data = 32'd0;
   logic [4:0]                   src1_addr = 5'd0;
   logic [4:0]                   src2_addr = 5'd0;
   logic [31:0]                  src1_value;
   logic [31:0]                  src2_value;
   logic                         wb_stall;
   logic [$clog2(DEPTH+1)-1:0]   queue_count;

   int checks = 0;
   int errors = 0;

   regfile_writeback #(.QUEUE_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .load_write_req  (load_write_req),
      .load_write_addr (load_write_addr),
      .load_write_data (load_write_data),
      .alu_write_req   (alu_write_req),
      .alu_write_addr  (alu_write_addr),
      .alu_write_data  (alu_write_data),
      .src1_addr       (src1_addr),
      .src2_addr       (src2_addr),
      .src1_value      (src1_value),
      .src2_value      (src2_value),
      .wb_stall        (wb_stall),
      .queue_count     (queue_count)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] mregs [32];
   bit          model_live = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_accepts();
      return alu_write_req && (mq.size() < DEPTH) && (alu_write_addr != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (model_accepts() && alu_write_addr == a) return alu_write_data;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].a == a) return mq[i].d;
      end
      if (load_write_req && load_write_addr == a) return load_write_data;
      return mregs[a];
   endfunction

   // Model state update at each rising edge.
   always @(posedge clk) begin
      if (!reset_n) begin
         mq.delete();
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         model_live = 1'b1;
      end else if (model_live) begin
         bit acc;
         ment_t e;
         acc = model_accepts();
         if (load_write_req) begin
            if (load_write_addr != 5'd0) mregs[load_write_addr] = load_write_data;
            if (acc) mq.push_back('{a: alu_write_addr, d: alu_write_data});
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mregs[e.a] = e.d;
            if (acc) mq.push_back('{a: alu_write_addr, d: alu_write_data});
         end else if (acc) begin
            mregs[alu_write_addr] = alu_write_data;
         end
      end
   end

   // Compare process: every falling edge while out of reset.
   always @(negedge clk) begin
      if (model_live && reset_n) begin
         check("src1_value", src1_value, exp_read(src1_addr));
         check("src2_value", src2_value, exp_read(src2_addr));
         check("wb_stall", 32'(wb_stall), 32'(mq.size() == DEPTH));
         check("queue_count", 32'(queue_count), 32'(mq.size()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic lr, input logic [4:0] la, input logic [31:0] ld,
                        input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] s1, input logic [4:0] s2);
      @(posedge clk);
      #1;
      load_write_req  = lr;
      load_write_addr = la;
      load_write_data = ld;
      alu_write_req   = ar;
      alu_write_addr  = aa;
      alu_write_data  = ad;
      src1_addr       = s1;
      src2_addr       = s2;
      #1;
   endtask

   task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      idle(5'd5, 5'd0);
      check("reset_x5", src1_value, 32'h0);
      check("reset_x0", src2_value, 32'h0);
      check("reset_stall", 32'(wb_stall), 32'd0);
      check("reset_count", 32'(queue_count), 32'd0);

      // Lone ALU write, bypass then array
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0);
      check("alu_bypass", src1_value, 32'h12345678);
      idle(5'd5, 5'd0);
      check("alu_array", src1_value, 32'h12345678);
      check("alu_count", 32'(queue_count), 32'd0);

      // Load + ALU collision on different registers
      drive(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h00000011, 5'd3, 5'd4);
      check("coll_load_byp", src1_value, 32'hAAAA0000);
      check("coll_alu_byp", src2_value, 32'h00000011);
      idle(5'd3, 5'd4);
      check("coll_count1", 32'(queue_count), 32'd1);
      check("coll_queued", src2_value, 32'h00000011);
      idle(5'd3, 5'd4);
      check("coll_count0", 32'(queue_count), 32'd0);
      check("coll_x3", src1_value, 32'hAAAA0000);
      check("coll_x4", src2_value, 32'h00000011);

      // Same-address collision: ALU data must win
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd0, 5'd7);
      check("same_byp", src2_value, 32'h2);
      idle(5'd0, 5'd7);
      check("same_queued", src2_value, 32'h2);
      idle(5'd0, 5'd7);
      check("same_final", src2_value, 32'h2);
      check("same_count", 32'(queue_count), 32'd0);

      // Back-to-back collisions fill the queue and raise wb_stall
      drive(1'b1, 5'd10, 32'h10000000, 1'b1, 5'd20, 32'h20000000, 5'd22, 5'd20);
      check("fill0_count", 32'(queue_count), 32'd0);
      drive(1'b1, 5'd11, 32'h10000001, 1'b1, 5'd21, 32'h20000001, 5'd22, 5'd20);
      check("fill1_count", 32'(queue_count), 32'd1);
      check("fill1_stall", 32'(wb_stall), 32'd0);
      drive(1'b1, 5'd12, 32'h10000002, 1'b1, 5'd22, 32'h20000002, 5'd22, 5'd20);
      check("fill2_stall", 32'(wb_stall), 32'd1);
      check("fill2_count", 32'(queue_count), 32'd2);
      check("fill2_no_fwd", src1_value, 32'h0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h20000002, 5'd22, 5'd20);
      check("fill3_stall", 32'(wb_stall), 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h20000002, 5'd22, 5'd20);
      check("fill4_stall", 32'(wb_stall), 32'd0);
      check("fill4_count", 32'(queue_count), 32'd1);
      check("fill4_fwd", src1_value, 32'h20000002);
      idle(5'd10, 5'd20);
      check("fill5_count", 32'(queue_count), 32'd1);
      idle(5'd10, 5'd20);
      check("fill6_count", 32'(queue_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         idle(5'(10 + i), 5'(20 + i));
         check("fill_load_reg", src1_value, 32'h10000000 + 32'(i));
         check("fill_alu_reg", src2_value, 32'h20000000 + 32'(i));
      end

      // Reset while the queue holds two entries
      drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd2, 5'd4);
      drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd2, 5'd4);
      @(posedge clk);
      #1;
      check("prereset_count", 32'(queue_count), 32'd2);
      reset_n = 1'b0;
      load_write_req = 1'b0;
      alu_write_req  = 1'b0;
      #1;
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_stall", 32'(wb_stall), 32'd0);
      check("rst_x2", src1_value, 32'h0);
      check("rst_x4", src2_value, 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         idle(5'(i), 5'(i + 16));
         check("post_rst_lo", src1_value, 32'h0);
         check("post_rst_hi", src2_value, 32'h0);
      end

      // Randomized traffic; upstream holds a stalled ALU write
      for (int n = 0; n < 3000; n++) begin
         logic        hold;
         logic        ar;
         logic [4:0]  aa;
         logic [31:0] ad;
         hold = wb_stall && alu_write_req;
         if (hold) begin
            ar = alu_write_req;
            aa = alu_write_addr;
            ad = alu_write_data;
         end else begin
            ar = ($urandom_range(0, 99) < 60);
            aa = rand_addr();
            ad = $urandom;
         end
         drive(($urandom_range(0, 99) < 45), rand_addr(), $urandom, ar, aa, ad,
               rand_addr(), rand_addr());
      end

      // Drain and sweep the whole array through the compare process
      for (int i = 0; i < 4; i++) idle(5'd0, 5'd0);
      for (int i = 0; i < 16; i++) idle(5'(i), 5'(i + 16));
      idle(5'd0, 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
